highway_interval_timer: RTL and testbench
=========================================

Name: highway_interval_timer

Overview:
- Interval timer directly upstream of the highway light FSM: generates the long (minimum green) count `Timeout` and the short (yellow) count `timeout` that the FSM compares against zero.
- Loads on the FSM's one-cycle `start_g_h` / `start_y_h` pulses, down-counts on a prescaled tick, and holds at zero until the next load.
- A small run-state FSM gates counting and raises one-cycle done pulses for status/debug.

Parameters:
- TIMEOUT_BIT, 4, width of `Timeout`.
- t_bit, 2, width of `timeout`.
- LONG_VAL, 9, `Timeout` load value; must fit TIMEOUT_BIT, must be ≥1.
- SHORT_VAL, 3, `timeout` load value; must fit t_bit, must be ≥1.
- TICK_DIV, 1, clock cycles per count step; must be ≥1. Prescaler width is clog2(TICK_DIV), minimum 1 bit.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start_g_h  input  1  one-cycle pulse from the light FSM; reload and start the long count.
- start_y_h  input  1  one-cycle pulse from the light FSM; reload and start the short count.
- Timeout  output  TIMEOUT_BIT  long count, registered.
- timeout  output  t_bit  short count, registered.
- long_done  output  1  one-cycle pulse in the cycle `Timeout` becomes 0 by counting.
- short_done  output  1  one-cycle pulse in the cycle `timeout` becomes 0 by counting.
- busy  output  1  high while in LONG or SHORT.

Behaviour:
- Reset values (rst high at a clock edge):
  - `Timeout` = LONG_VAL, `timeout` = SHORT_VAL, prescaler = 0, state = LONG, `busy` = 1, `long_done` = `short_done` = 0.
  - This matches the light FSM resetting into green.
- rst overrides every other input, including mid-count.
- States (one-hot or binary, implementer's choice):
  - IDLE: neither counter active.
  - LONG: `Timeout` counting.
  - SHORT: `timeout` counting.
- Load (registered, one-cycle latency), checked every cycle regardless of state:
  - `start_g_h` = 1: next `Timeout` = LONG_VAL, prescaler = 0, state = LONG.
  - `start_y_h` = 1: next `timeout` = SHORT_VAL, prescaler = 0, state = SHORT.
  - Both high in the same cycle: `start_g_h` wins; `timeout` is left unchanged.
  - A load during an active count aborts that count. No done pulse is issued for the aborted count.
- Tick:
  - In LONG or SHORT with no load, the prescaler increments.
  - When the prescaler equals TICK_DIV-1, it wraps to 0 and the active counter decrements by 1.
  - With TICK_DIV = 1, the counter decrements every cycle.
- Reaching zero:
  - The decrement that produces 0 asserts the matching done pulse in the same cycle the counter reads 0.
  - The state goes to IDLE on that cycle.
  - The counter then holds 0 in IDLE until its own reload.
- Inactive counter: the counter not selected by the state holds its value. For example, `timeout` stays at 0 through green and red after yellow expires.
- No wrap-around: the counters never decrement below 0 and never increment.
- Interval: the counter reads 0 exactly LOAD×TICK_DIV cycles after the first cycle it shows LOAD.
- `busy` = (state != IDLE), registered with the state.
- The done pulses are registered and are never high for two consecutive cycles.

Optional Feature:
- Macro: HWY_TIMER_PAUSE_EN.
- Defined:
  - Adds input port `pause` (1 bit).
  - While `pause` = 1 the prescaler and both counters freeze; the state and `busy` are unchanged.
  - Loads still take effect during pause.
  - Rising-edge/falling-edge of `pause` cause no extra tick; counting resumes from the frozen prescaler value.
- Not defined: no `pause` port; counting is never frozen.

Test Plan:
- Reset, defaults: hold rst for 2 cycles, release → `Timeout` = 9, `timeout` = 3, `busy` = 1. `Timeout` steps 8..0 on the following 9 edges. `long_done` = 1 only on the edge `Timeout` = 0. State becomes IDLE and `Timeout` holds 0 for 20 cycles.
- Yellow load: from IDLE, pulse `start_y_h` 1 cycle → next edge `timeout` = 3. It then reads 2, 1, 0 on the next 3 edges, with `short_done` on the 0 edge. `Timeout` stays 0 throughout.
- Prescale: TICK_DIV = 3, pulse `start_g_h` → `Timeout` = 9, then decrements every 3rd cycle and reaches 0 exactly 27 cycles later.
- Abort/priority:
  - Pulse `start_g_h` while `Timeout` = 4 → `Timeout` = 9 next edge, with no `long_done`.
  - Pulse `start_g_h` and `start_y_h` together → `Timeout` = 9 and `timeout` unchanged.
- Reset mid-count: assert rst while in SHORT with `timeout` = 1 → next edge `Timeout` = 9, `timeout` = 3, state LONG, no `short_done`.
- Pause (HWY_TIMER_PAUSE_EN defined): hold `pause` for 5 cycles at `Timeout` = 6 → `Timeout` stays 6. After release it resumes 5, 4, … with no skipped or extra step.

Source files
------------

// File: rtl/highway_interval_timer.sv
// Interval timer for the highway light FSM: long (green) and short (yellow) down-counters
// with a prescaled tick. Optional macro HWY_TIMER_PAUSE_EN adds a `pause` input that freezes counting.
module highway_interval_timer #(
    parameter int unsigned TIMEOUT_BIT = 4,
    parameter int unsigned t_bit       = 2,
    parameter int unsigned LONG_VAL    = 9,
    parameter int unsigned SHORT_VAL   = 3,
    parameter int unsigned TICK_DIV    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef HWY_TIMER_PAUSE_EN
    input  logic                   pause,
`endif
    input  logic                   start_g_h,
    input  logic                   start_y_h,
    output logic [TIMEOUT_BIT-1:0] Timeout,
    output logic [t_bit-1:0]       timeout,
    output logic                   long_done,
    output logic                   short_done,
    output logic                   busy
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LONG  = 2'd1,
        S_SHORT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [TIMEOUT_BIT-1:0] long_q, long_d;
    logic [t_bit-1:0]       short_q, short_d;
    logic [PRE_W-1:0]       pre_q, pre_d;
    logic                   long_done_q, long_done_d;
    logic                   short_done_q, short_done_d;
    logic                   busy_q, busy_d;
    logic                   run_c;

`ifdef HWY_TIMER_PAUSE_EN
    assign run_c = ~pause;
`else
    assign run_c = 1'b1;
`endif

    // Next-state: loads take priority over ticking; green load beats yellow load.
    always_comb begin
        state_d      = state_q;
        long_d       = long_q;
        short_d      = short_q;
        pre_d        = pre_q;
        long_done_d  = 1'b0;
        short_done_d = 1'b0;

        if (start_g_h) begin
            long_d  = TIMEOUT_BIT'(LONG_VAL);
            pre_d   = '0;
            state_d = S_LONG;
        end else if (start_y_h) begin
            short_d = t_bit'(SHORT_VAL);
            pre_d   = '0;
            state_d = S_SHORT;
        end else if ((state_q != S_IDLE) && run_c) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (state_q == S_LONG) begin
                    if (long_q == TIMEOUT_BIT'(1)) begin
                        long_d      = '0;
                        long_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (long_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        long_d = long_q - TIMEOUT_BIT'(1);
                    end
                end else begin
                    if (short_q == t_bit'(1)) begin
                        short_d      = '0;
                        short_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else if (short_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        short_d = short_q - t_bit'(1);
                    end
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // Reset lands in the green interval, matching the light FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LONG;
            long_q       <= TIMEOUT_BIT'(LONG_VAL);
            short_q      <= t_bit'(SHORT_VAL);
            pre_q        <= '0;
            long_done_q  <= 1'b0;
            short_done_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            long_q       <= long_d;
            short_q      <= short_d;
            pre_q        <= pre_d;
            long_done_q  <= long_done_d;
            short_done_q <= short_done_d;
            busy_q       <= busy_d;
        end
    end

    assign Timeout    = long_q;
    assign timeout    = short_q;
    assign long_done  = long_done_q;
    assign short_done = short_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_highway_interval_timer.sv
// Scoreboard bench for highway_interval_timer: instance A (TICK_DIV=1) and instance B (TICK_DIV=3).
module tb_highway_interval_timer;

    logic clk;
    logic rst_a, g_a, y_a, pause_a;
    logic rst_b, g_b, y_b, pause_b;

    logic [3:0] big_a, big_b;
    logic [1:0] sml_a, sml_b;
    logic       ld_a, sd_a, busy_a;
    logic       ld_b, sd_b, busy_b;

    int checks = 0;
    int errors = 0;

    // Expected record packed as {Timeout, timeout, long_done, short_done, busy}
    int         q_id[$];
    logic [8:0] q_exp[$];
    string      q_tag[$];

    int         mon_id;
    logic [8:0] mon_exp, mon_act;
    string      mon_tag;

    highway_interval_timer #(
        .TIMEOUT_BIT(4), .t_bit(2), .LONG_VAL(9), .SHORT_VAL(3), .TICK_DIV(1)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
`ifdef HWY_TIMER_PAUSE_EN
        .pause     (pause_a),
`endif
        .start_g_h (g_a),
        .start_y_h (y_a),
        .Timeout   (big_a),
        .timeout   (sml_a),
        .long_done (ld_a),
        .short_done(sd_a),
        .busy      (busy_a)
    );

    highway_interval_timer #(
        .TIMEOUT_BIT(4), .t_bit(2), .LONG_VAL(9), .SHORT_VAL(3), .TICK_DIV(3)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst_b),
`ifdef HWY_TIMER_PAUSE_EN
        .pause     (pause_b),
`endif
        .start_g_h (g_b),
        .start_y_h (y_b),
        .Timeout   (big_b),
        .timeout   (sml_b),
        .long_done (ld_b),
        .short_done(sd_b),
        .busy      (busy_b)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input int id, input logic [3:0] e_big, input logic [1:0] e_sml,
                            input logic e_ld, input logic e_sd, input logic e_busy, input string tag);
        q_id.push_back(id);
        q_exp.push_back({e_big, e_sml, e_ld, e_sd, e_busy});
        q_tag.push_back(tag);
    endtask

    task automatic step_a(input logic r, input logic g, input logic y,
                          input logic [3:0] e_big, input logic [1:0] e_sml,
                          input logic e_ld, input logic e_sd, input logic e_busy, input string tag);
        @(negedge clk);
        rst_a = r; g_a = g; y_a = y;
        @(posedge clk);
        #1;
        push_exp(0, e_big, e_sml, e_ld, e_sd, e_busy, tag);
    endtask

    task automatic step_b(input logic r, input logic g, input logic y,
                          input logic [3:0] e_big, input logic [1:0] e_sml,
                          input logic e_ld, input logic e_sd, input logic e_busy, input string tag);
        @(negedge clk);
        rst_b = r; g_b = g; y_b = y;
        @(posedge clk);
        #1;
        push_exp(1, e_big, e_sml, e_ld, e_sd, e_busy, tag);
    endtask

    // Monitor: outputs are presented every cycle; compare each queued expectation mid-cycle.
    always @(negedge clk) begin
        while (q_id.size() > 0) begin
            mon_id  = q_id.pop_front();
            mon_exp = q_exp.pop_front();
            mon_tag = q_tag.pop_front();
            mon_act = (mon_id == 0) ? {big_a, sml_a, ld_a, sd_a, busy_a}
                                    : {big_b, sml_b, ld_b, sd_b, busy_b};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s (dut %0d): got Timeout=%0d timeout=%0d long_done=%b short_done=%b busy=%b, want Timeout=%0d timeout=%0d long_done=%b short_done=%b busy=%b",
                         mon_tag, mon_id,
                         mon_act[8:5], mon_act[4:3], mon_act[2], mon_act[1], mon_act[0],
                         mon_exp[8:5], mon_exp[4:3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 1'b0;
        rst_a = 1'b1; g_a = 1'b0; y_a = 1'b0; pause_a = 1'b0;
        rst_b = 1'b1; g_b = 1'b0; y_b = 1'b0; pause_b = 1'b0;

        // Reset defaults, then the long count runs out
        repeat (2) step_a(1, 0, 0, 4'd9, 2'd3, 0, 0, 1, "reset");
        for (int i = 8; i >= 0; i--)
            step_a(0, 0, 0, 4'(i), 2'd3, i == 0, 0, i != 0, "long_count");
        repeat (20) step_a(0, 0, 0, 4'd0, 2'd3, 0, 0, 0, "idle_hold");

        // Yellow load from IDLE
        step_a(0, 0, 1, 4'd0, 2'd3, 0, 0, 1, "y_load");
        for (int i = 2; i >= 0; i--)
            step_a(0, 0, 0, 4'd0, 2'(i), 0, i == 0, i != 0, "short_count");

        // Abort a green count at 4 with a reload
        step_a(0, 1, 0, 4'd9, 2'd0, 0, 0, 1, "g_load");
        for (int i = 8; i >= 4; i--)
            step_a(0, 0, 0, 4'(i), 2'd0, 0, 0, 1, "pre_abort");
        step_a(0, 1, 0, 4'd9, 2'd0, 0, 0, 1, "abort_reload");
        for (int i = 8; i >= 0; i--)
            step_a(0, 0, 0, 4'(i), 2'd0, i == 0, 0, i != 0, "after_abort");

        // Simultaneous loads: green wins, short count left alone
        step_a(0, 0, 1, 4'd0, 2'd3, 0, 0, 1, "y_load2");
        step_a(0, 0, 0, 4'd0, 2'd2, 0, 0, 1, "y_step");
        step_a(0, 1, 1, 4'd9, 2'd2, 0, 0, 1, "both_load");
        step_a(0, 0, 0, 4'd8, 2'd2, 0, 0, 1, "g_wins");

        // Reset while SHORT at 1
        step_a(0, 0, 1, 4'd8, 2'd3, 0, 0, 1, "y_abort_long");
        step_a(0, 0, 0, 4'd8, 2'd2, 0, 0, 1, "short_at_2");
        step_a(0, 0, 0, 4'd8, 2'd1, 0, 0, 1, "short_at_1");
        step_a(1, 0, 0, 4'd9, 2'd3, 0, 0, 1, "mid_reset");
        step_a(0, 0, 0, 4'd8, 2'd3, 0, 0, 1, "post_reset");
        for (int i = 7; i >= 0; i--)
            step_a(0, 0, 0, 4'(i), 2'd3, i == 0, 0, i != 0, "post_reset_count");

`ifdef HWY_TIMER_PAUSE_EN
        // Pause for 5 cycles at 6
        step_a(0, 1, 0, 4'd9, 2'd3, 0, 0, 1, "p_load");
        for (int i = 8; i >= 6; i--)
            step_a(0, 0, 0, 4'(i), 2'd3, 0, 0, 1, "p_pre");
        pause_a = 1'b1;
        repeat (5) step_a(0, 0, 0, 4'd6, 2'd3, 0, 0, 1, "p_hold");
        pause_a = 1'b0;
        for (int i = 5; i >= 0; i--)
            step_a(0, 0, 0, 4'(i), 2'd3, i == 0, 0, i != 0, "p_resume");
`endif

        // Prescaled instance: one step every 3 cycles, zero 27 cycles after load
        step_b(1, 0, 0, 4'd9, 2'd3, 0, 0, 1, "b_reset");
        step_b(0, 1, 0, 4'd9, 2'd3, 0, 0, 1, "b_load");
        for (int n = 1; n <= 27; n++)
            step_b(0, 0, 0, 4'(9 - n / 3), 2'd3, n == 27, 0, n != 27, "b_prescale");
        repeat (3) step_b(0, 0, 0, 4'd0, 2'd3, 0, 0, 0, "b_idle");

        @(negedge clk);
        #1;
        checks++;
        if (q_id.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q_id.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
